// File: rtl/spi_reg_master.sv
// SPI mode-0 initiator that turns valid/ready register commands into
// raybox-zero register-load frames: 4-bit address then MSB-first payload.
module spi_reg_master #(
  parameter int CLK_DIV     = 2,
  parameter int MAX_PAYLOAD = 24
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [3:0]             cmd_addr,
  input  logic [MAX_PAYLOAD-1:0] cmd_data,
  input  logic [4:0]             cmd_len,
  output logic                   busy,
  output logic                   done,
  output logic                   spi_sclk,
  output logic                   spi_mosi,
  output logic                   spi_csb
);

  localparam int             SW       = MAX_PAYLOAD + 4;
  localparam int             BW       = $clog2(SW + 1);
  localparam logic [7:0]     DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [4:0]     MAX_LEN  = 5'(MAX_PAYLOAD);

  typedef enum logic [2:0] {IDLE, LEAD, HIGH, LOW, GAP} state_t;

  state_t          r_state, w_state;
  logic [7:0]      r_div, w_div;
  logic [BW-1:0]   r_bits, w_bits;
  logic [SW-1:0]   r_shift, w_shift;
  logic            r_sclk, w_sclk;
  logic            r_mosi, w_mosi;
  logic            r_csb, w_csb;
  logic            r_ready, w_ready;
  logic            r_busy, w_busy;
  logic            r_done, w_done;

  logic [4:0]      w_len;
  logic [SW-1:0]   w_load;
  logic [BW-1:0]   w_nbits;
  logic            w_phaseEnd;

  // Payload is left-justified under the address so the frame always leaves from the MSB.
  assign w_len      = (cmd_len > MAX_LEN) ? MAX_LEN : cmd_len;
  assign w_load     = {cmd_addr, cmd_data << (MAX_LEN - w_len)};
  assign w_nbits    = BW'(w_len) + BW'(4);
  assign w_phaseEnd = (r_div == 8'd0);

  always_comb begin
    w_state = r_state;
    w_div   = w_phaseEnd ? DIV_LAST : r_div - 8'd1;
    w_bits  = r_bits;
    w_shift = r_shift;
    w_sclk  = r_sclk;
    w_mosi  = r_mosi;
    w_csb   = r_csb;
    w_done  = 1'b0;
    case (r_state)
      IDLE: begin
        w_div = DIV_LAST;
        if (cmd_valid && r_ready) begin
          w_state = LEAD;
          w_shift = w_load;
          w_mosi  = w_load[SW-1];
          w_bits  = w_nbits;
          w_csb   = 1'b0;
          w_sclk  = 1'b0;
        end
      end
      LEAD: begin
        if (w_phaseEnd) begin
          w_state = HIGH;
          w_sclk  = 1'b1;
        end
      end
      HIGH: begin
        if (w_phaseEnd) begin
          w_state = LOW;
          w_sclk  = 1'b0;
          w_bits  = r_bits - BW'(1);
          if (r_bits > BW'(1)) begin
            w_shift = r_shift << 1;
            w_mosi  = r_shift[SW-2];
          end
        end
      end
      LOW: begin
        // After the final bit this phase doubles as chip-select hold time.
        if (w_phaseEnd) begin
          if (r_bits != '0) begin
            w_state = HIGH;
            w_sclk  = 1'b1;
          end else begin
            w_state = GAP;
            w_csb   = 1'b1;
            w_mosi  = 1'b0;
            w_done  = 1'b1;
          end
        end
      end
      GAP: begin
        if (w_phaseEnd) w_state = IDLE;
      end
      default: w_state = IDLE;
    endcase
    w_ready = (w_state == IDLE);
    w_busy  = (w_state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_div   <= 8'd0;
      r_bits  <= '0;
      r_shift <= '0;
      r_sclk  <= 1'b0;
      r_mosi  <= 1'b0;
      r_csb   <= 1'b1;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_div   <= w_div;
      r_bits  <= w_bits;
      r_shift <= w_shift;
      r_sclk  <= w_sclk;
      r_mosi  <= w_mosi;
      r_csb   <= w_csb;
      r_ready <= w_ready;
      r_busy  <= w_busy;
      r_done  <= w_done;
    end
  end

  assign cmd_ready = r_ready;
  assign busy      = r_busy;
  assign done      = r_done;
  assign spi_sclk  = r_sclk;
  assign spi_mosi  = r_mosi;
  assign spi_csb   = r_csb;

endmodule

// File: doc/spi_reg_master.md
Name: spi_reg_master

Overview:
- SPI initiator that drives raybox-zero's register-load port (spi_sclk, spi_mosi, spi_csb) from a simple valid/ready command interface.
- Used by the on-board/FPGA-side controller and by the testbench, replacing bit-banged cocotb SPI writes.
- Each command is one frame: a 4-bit register address followed by a variable-length payload, MSB first, SPI mode 0.

Parameters:
- CLK_DIV, 2, SCLK half-period in clk cycles; legal range 1..255.
- MAX_PAYLOAD, 24, maximum payload bits per frame.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- cmd_valid  input  1  command offered
- cmd_ready  output  1  block can accept a command
- cmd_addr  input  4  register address, sent first, bit 3 first
- cmd_data  input  MAX_PAYLOAD  payload, right-aligned; cmd_data[cmd_len-1] is sent first
- cmd_len  input  5  payload bit count, 0..MAX_PAYLOAD
- busy  output  1  frame in progress (csb low or gap)
- done  output  1  one-cycle pulse when a frame completes
- spi_sclk  output  1  SPI clock to raybox-zero
- spi_mosi  output  1  SPI data to raybox-zero
- spi_csb  output  1  SPI chip select, active low

Behaviour:
- One clock domain. All outputs are registered; no combinational path from the inputs to the SPI pins.
- Reset values: spi_csb=1, spi_sclk=0, spi_mosi=0, cmd_ready=1, busy=0, done=0.
- Frame bit count nbits = 4 + min(cmd_len, MAX_PAYLOAD). cmd_len=0 gives an address-only frame of 4 bits.
- Inputs are latched on the accept cycle (cmd_valid & cmd_ready). Later changes to the inputs have no effect on the frame.
- Shift register holds {cmd_addr, cmd_data << (MAX_PAYLOAD-len)}, MSB first.
- States: IDLE, LEAD, HIGH, LOW, GAP. A divider counter counts CLK_DIV cycles per phase; a bit counter counts remaining bits.
- IDLE: cmd_ready=1, busy=0.
  - On accept, the next cycle has spi_csb=0, spi_sclk=0, spi_mosi=first bit, state LEAD, cmd_ready=0, busy=1.
- LEAD: CLK_DIV cycles with sclk low (MOSI setup), then go to HIGH.
- HIGH: spi_sclk=1 for CLK_DIV cycles; the receiver samples MOSI on the rising edge. Then go to LOW.
- LOW: spi_sclk=0 for CLK_DIV cycles.
  - If bits remain, spi_mosi takes the next bit on the first LOW cycle, coincident with the falling edge. Return to HIGH after the count.
  - After the last bit, LOW acts as CSB hold and spi_mosi stays at the last bit. After the count: spi_csb=1, spi_mosi=0, state GAP, done=1 for exactly that first GAP cycle.
- GAP: spi_csb high for CLK_DIV cycles with cmd_ready=0 and busy=1, then IDLE.
- Frame timing:
  - spi_csb is low for exactly CLK_DIV*(1+2*nbits) cycles.
  - Exactly nbits rising edges occur.
  - cmd_ready returns CLK_DIV cycles after spi_csb rises.
- Back-to-back commands: cmd_valid held high is accepted on the first IDLE cycle. The minimum CSB-high time between frames is CLK_DIV+1 cycles.
- cmd_len > MAX_PAYLOAD is clamped to MAX_PAYLOAD. The low MAX_PAYLOAD bits of cmd_data are used.
- cmd_valid while not ready is ignored; no queueing.
- reset asserted mid-frame: the next cycle returns to the reset values. spi_csb goes high with no done pulse. A partial frame is allowed; raybox-zero discards frames on CSB rise.
- reset and cmd_valid in the same cycle: reset wins and the command is not accepted.
- CLK_DIV=1: SCLK = clk/2, and all rules above still hold.

Test Plan:
- Reset values: after reset, check csb=1, sclk=0, mosi=0, ready=1, busy=0. Assert reset during a frame's 5th HIGH phase → csb=1 the next cycle and no done pulse.
- Normal frame: CLK_DIV=2, addr=4'h0, len=6, data=6'h2A, accept at cycle 0.
  - MOSI sampled at 10 rising edges = 0000101010.
  - csb low for cycles 1..42 (42 cycles).
  - done=1 at cycle 43; ready=1 at cycle 45.
- Full-length frame: addr=4'h3, len=24, data=24'hA5C3F0 → 28 rising edges, bits 0011 then A5C3F0 MSB first; csb low 2*57=114 cycles.
- Address-only and clamped frames:
  - len=0, addr=4'hF → 4 edges of 1111, csb low 18 cycles.
  - len=31 → clamps to 24 payload bits, 28 edges.
- Back-to-back: cmd_valid held high with 3 queued commands → 3 frames, exactly 3 done pulses, csb high CLK_DIV+1=3 cycles between frames. Inputs changed mid-frame do not alter MOSI.
- End-to-end: with CLK_DIV=1, connect to tt_um_algofoogle_raybox_zero and write a player-position register → the DUT register reads back the written value, and no MOSI transition occurs while sclk is high.
